// File: rtl/acl_spi_responder.sv
// ADXL362-style SPI-slave responder: oversampled mode-0 SPI, register reads/writes.
// Optional ACL_SPI_RESP_AUTOINC_EN: address pointer advances after each data byte.
module acl_spi_responder #(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_i,
    input  logic        csn_i,
    input  logic        mosi_i,
    output logic        miso_o,
    input  logic [11:0] sample_x_i,
    input  logic [11:0] sample_y_i,
    input  logic [11:0] sample_z_i,
    input  logic        sample_valid_i,
    output logic        cfg_wr_o,
    output logic [5:0]  cfg_addr_o,
    output logic [7:0]  cfg_wdata_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES:0]   sclk_q, csn_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

    logic [2:0]  bit_q;
    logic [7:0]  shin_q, shout_q, byte_in, rdata;
    logic [5:0]  ptr_q, ptr_nxt;
    logic [3:0]  ram_idx;
    logic [7:0]  ram_q [16];
    logic        wr_q, load_q, dr_q, dr_d, soft_q, miso_q;
    logic        cfg_wr_q;
    logic [5:0]  cfg_addr_q;
    logic [7:0]  cfg_wdata_q;
    logic [11:0] lx_q, ly_q, lz_q, sx_q, sy_q, sz_q;
    logic        shift_en, byte_done, in_ram;

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign csn_fall  = ~csn_q[SYNC_STAGES-1] & csn_q[SYNC_STAGES];
    assign csn_rise  = csn_q[SYNC_STAGES-1] & ~csn_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

    assign byte_in   = {shin_q[6:0], mosi_s};
    assign byte_done = shift_en && (bit_q == 3'd7);
    assign in_ram    = (ptr_q >= 6'h1F) && (ptr_q <= 6'h2E);
    // ptr - 0x1F folded into the low nibble
    assign ram_idx   = ptr_q[3:0] - 4'hF;

`ifdef ACL_SPI_RESP_AUTOINC_EN
    assign ptr_nxt = ptr_q + 6'd1;
`else
    assign ptr_nxt = ptr_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        if (csn_rise) begin
            state_d = IDLE;
        end else if (csn_fall) begin
            state_d = CMD;
        end else if (sclk_rise) begin
            unique case (state_q)
                CMD: begin
                    shift_en = 1'b1;
                    if (bit_q == 3'd7)
                        state_d = (byte_in == 8'h0A || byte_in == 8'h0B) ? ADDR : IGNORE;
                end
                ADDR: begin
                    shift_en = 1'b1;
                    if (bit_q == 3'd7) state_d = wr_q ? WDATA : RDATA;
                end
                WDATA, RDATA: shift_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (ptr_q)
            6'h00: rdata = DEVID_AD;
            6'h01: rdata = 8'h1D;
            6'h02: rdata = PARTID;
            6'h03: rdata = 8'h01;
            6'h08: rdata = sx_q[11:4];
            6'h09: rdata = sy_q[11:4];
            6'h0A: rdata = sz_q[11:4];
            6'h0B: rdata = {7'b0, dr_q};
            6'h0E: rdata = sx_q[7:0];
            6'h0F: rdata = {{4{sx_q[11]}}, sx_q[11:8]};
            6'h10: rdata = sy_q[7:0];
            6'h11: rdata = {{4{sy_q[11]}}, sy_q[11:8]};
            6'h12: rdata = sz_q[7:0];
            6'h13: rdata = {{4{sz_q[11]}}, sz_q[11:8]};
            default: if (in_ram && ptr_q != 6'h1F) rdata = ram_q[ram_idx];
        endcase
    end

    // set from a new sample wins over any clear in the same cycle
    always_comb begin
        dr_d = dr_q;
        if (soft_q || (byte_done && state_q == RDATA && ptr_q == 6'h0B)) dr_d = 1'b0;
        if (sample_valid_i) dr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            csn_q       <= '1;
            mosi_q      <= '0;
            bit_q       <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            ptr_q       <= '0;
            wr_q        <= 1'b0;
            load_q      <= 1'b0;
            dr_q        <= 1'b0;
            soft_q      <= 1'b0;
            miso_q      <= 1'b0;
            cfg_wr_q    <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            lx_q <= '0; ly_q <= '0; lz_q <= '0;
            sx_q <= '0; sy_q <= '0; sz_q <= '0;
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
        end else begin
            sclk_q   <= {sclk_q[SYNC_STAGES-1:0], sclk_i};
            csn_q    <= {csn_q[SYNC_STAGES-1:0], csn_i};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            cfg_wr_q <= 1'b0;
            soft_q   <= 1'b0;
            dr_q     <= dr_d;
            if (sample_valid_i) begin
                lx_q <= sample_x_i;
                ly_q <= sample_y_i;
                lz_q <= sample_z_i;
            end
            if (csn_fall) begin
                sx_q <= lx_q;
                sy_q <= ly_q;
                sz_q <= lz_q;
            end
            if (csn_rise || csn_fall) begin
                bit_q  <= '0;
                load_q <= 1'b0;
                miso_q <= 1'b0;
            end else if (shift_en) begin
                shin_q <= byte_in;
                bit_q  <= bit_q + 3'd1;
                if (byte_done) begin
                    unique case (state_q)
                        CMD:  wr_q <= (byte_in == 8'h0A);
                        ADDR: begin
                            ptr_q  <= byte_in[5:0];
                            load_q <= ~wr_q;
                        end
                        WDATA: begin
                            if (in_ram) begin
                                ram_q[ram_idx] <= byte_in;
                                cfg_wr_q       <= 1'b1;
                                cfg_addr_q     <= ptr_q;
                                cfg_wdata_q    <= byte_in;
                                soft_q <= (ptr_q == 6'h1F) && (byte_in == 8'h52);
                            end
                            ptr_q <= ptr_nxt;
                        end
                        RDATA: begin
                            ptr_q  <= ptr_nxt;
                            load_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall && state_q == RDATA) begin
                load_q <= 1'b0;
                if (load_q) begin
                    miso_q  <= rdata[7];
                    shout_q <= {rdata[6:0], 1'b0};
                end else begin
                    miso_q  <= shout_q[7];
                    shout_q <= {shout_q[6:0], 1'b0};
                end
            end
            if (soft_q) begin
                for (int i = 0; i < 16; i++) ram_q[i] <= '0;
            end
        end
    end

    assign miso_o      = miso_q;
    assign cfg_wr_o    = cfg_wr_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign cfg_wdata_o = cfg_wdata_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: vector table, directed sequences, random vs model.
// Follows ACL_SPI_RESP_AUTOINC_EN for the expected burst addressing.
module tb_acl_spi_responder;

`ifdef ACL_SPI_RESP_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic        miso;
    logic [11:0] sx = '0, sy = '0, sz = '0;
    logic        sv = 1'b0;
    logic        cfg_wr;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_wdata;

    acl_spi_responder dut (
        .clk(clk), .rst_n(rst_n),
        .sclk_i(sclk), .csn_i(csn), .mosi_i(mosi), .miso_o(miso),
        .sample_x_i(sx), .sample_y_i(sy), .sample_z_i(sz),
        .sample_valid_i(sv),
        .cfg_wr_o(cfg_wr), .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [13:0] got_q[$];
    logic [13:0] eq[$];
    logic [7:0]  txb[8], rxb[8];

    // reference state
    logic [7:0]  m_ram[16];
    logic        m_dr;
    logic [11:0] live[3], sh[3];

    always @(negedge clk) if (cfg_wr) got_q.push_back({cfg_addr, cfg_wdata});

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input logic [13:0] exp_q[$]);
        chk({nm, " count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s pulse%0d", nm, i),
                (i < got_q.size()) ? got_q[i] : 14'hx, exp_q[i]);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            clks(HALF);
            rx[i] = miso;
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_on();
        csn = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_off();
        clks(HALF);
        csn = 1'b1;
        clks(HALF + 2);
    endtask

    task automatic xact(input logic [7:0] cmd, input logic [7:0] adr, input int n);
        logic [7:0] d;
        got_q.delete();
        cs_on();
        spi_bits(cmd, 8, d);
        spi_bits(adr, 8, d);
        for (int i = 0; i < n; i++) spi_bits(txb[i], 8, rxb[i]);
        cs_off();
    endtask

    task automatic sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        sx = x; sy = y; sz = z; sv = 1'b1;
        clks(1);
        sv = 1'b0;
        live[0] = x; live[1] = y; live[2] = z;
        m_dr = 1'b1;
    endtask

    function automatic logic [7:0] m_read(input int a);
        logic [11:0] s;
        if (a >= 8 && a <= 10) begin
            s = sh[a-8];
            return s[11:4];
        end
        if (a >= 14 && a <= 19) begin
            s = sh[(a-14)/2];
            return (a % 2 == 0) ? s[7:0] : 8'($signed(s) >>> 8);
        end
        if (a >= 32 && a <= 46) return m_ram[a-31];
        case (a)
            0: return 8'hAD;
            1: return 8'h1D;
            2: return 8'hF2;
            3: return 8'h01;
            11: return {7'b0, m_dr};
            default: return 8'h00;
        endcase
    endfunction

    task automatic rnd_xact(input int t);
        int wr, len, p;
        logic [7:0] a;
        wr  = $urandom_range(0, 1);
        len = $urandom_range(1, 4);
        a   = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 4) == 0) a = 8'h3E;
        p   = int'(a[5:0]);
        for (int i = 0; i < len; i++) txb[i] = 8'($urandom);
        if (wr == 1 && p == 31 && $urandom_range(0, 1) == 1) txb[0] = 8'h52;
        for (int i = 0; i < 3; i++) sh[i] = live[i];
        eq.delete();
        xact(wr == 1 ? 8'h0A : 8'h0B, a, len);
        for (int i = 0; i < len; i++) begin
            if (wr == 1) begin
                if (p >= 31 && p <= 46) begin
                    m_ram[p-31] = txb[i];
                    eq.push_back({6'(p), txb[i]});
                    if (p == 31 && txb[i] == 8'h52) begin
                        foreach (m_ram[k]) m_ram[k] = '0;
                        m_dr = 1'b0;
                    end
                end
            end else begin
                chk($sformatf("rnd%0d rd@%02h", t, p), rxb[i], m_read(p));
                if (p == 11) m_dr = 1'b0;
            end
            p = AI ? (p + 1) % 64 : p;
        end
        chk_wr($sformatf("rnd%0d wr", t), eq);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] adr;
        logic [7:0] wd;
        logic [7:0] rx;
        bit         wr;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [7:0] e[6];
        logic [7:0] d;

        tbl[0]  = '{8'h0B, 8'h00, 8'h00, 8'hAD, 1'b0};
        tbl[1]  = '{8'h0B, 8'h01, 8'h00, 8'h1D, 1'b0};
        tbl[2]  = '{8'h0B, 8'h02, 8'h00, 8'hF2, 1'b0};
        tbl[3]  = '{8'h0B, 8'h03, 8'h00, 8'h01, 1'b0};
        tbl[4]  = '{8'h0B, 8'h0B, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{8'h0A, 8'h2C, 8'h13, 8'h00, 1'b1};
        tbl[6]  = '{8'h0B, 8'h2C, 8'h00, 8'h13, 1'b0};
        tbl[7]  = '{8'h0A, 8'h2F, 8'h55, 8'h00, 1'b0};
        tbl[8]  = '{8'h0B, 8'h2F, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{8'h0A, 8'h1F, 8'h77, 8'h00, 1'b1};
        tbl[10] = '{8'h0B, 8'h1F, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{8'h0A, 8'h1E, 8'h11, 8'h00, 1'b0};
        tbl[12] = '{8'h0C, 8'h2C, 8'hFF, 8'h00, 1'b0};
        tbl[13] = '{8'h0B, 8'h2E, 8'h00, 8'h00, 1'b0};
        tbl[14] = '{8'h0A, 8'h2E, 8'hA5, 8'h00, 1'b1};
        tbl[15] = '{8'h0B, 8'h2E, 8'h00, 8'hA5, 1'b0};
        tbl[16] = '{8'h0B, 8'h3F, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{8'h0B, 8'h0E, 8'h00, 8'h00, 1'b0};
        tbl[18] = '{8'h0B, 8'h6C, 8'h00, 8'h13, 1'b0};
        tbl[19] = '{8'h0B, 8'h20, 8'h00, 8'h00, 1'b0};

        clks(5);
        rst_n = 1'b1;
        clks(2);
        chk("rst miso", miso, 1'b0);
        chk("rst cfg_wr", cfg_wr, 1'b0);
        chk("rst cfg_addr", cfg_addr, 6'h00);
        chk("rst cfg_wdata", cfg_wdata, 8'h00);

        e = '{8'hAD, 8'h1D, 8'hF2, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) txb[i] = 8'h00;
        xact(8'h0B, 8'h00, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("id burst b%0d", i), rxb[i], AI ? e[i] : e[0]);
        chk("id burst wr", got_q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            txb[0] = tbl[i].wd;
            xact(tbl[i].cmd, tbl[i].adr, 1);
            chk($sformatf("vec%0d rx", i), rxb[0], tbl[i].rx);
            chk($sformatf("vec%0d wr", i), got_q.size(), tbl[i].wr);
            if (tbl[i].wr)
                chk($sformatf("vec%0d pulse", i), got_q[0], {tbl[i].adr[5:0], tbl[i].wd});
        end

        sample(12'h9AB, 12'h123, 12'h7FF);
        txb[0] = 8'h00;
        xact(8'h0B, 8'h0B, 1);
        chk("status set", rxb[0], 8'h01);
        e = '{8'hAB, 8'hF9, 8'h23, 8'h01, 8'hFF, 8'h07};
        for (int i = 0; i < 6; i++) begin
            xact(8'h0B, 8'(8'h0E + i), 1);
            chk($sformatf("sample@%02h", 8'h0E + i), rxb[0], e[i]);
        end
        for (int i = 0; i < 6; i++) txb[i] = 8'h00;
        xact(8'h0B, 8'h0E, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("sample burst b%0d", i), rxb[i], AI ? e[i] : e[0]);
        xact(8'h0B, 8'h0B, 1);
        chk("status clr", rxb[0], 8'h00);

        txb[0] = 8'h13; txb[1] = 8'h02;
        xact(8'h0A, 8'h2C, 2);
        eq.delete();
        eq.push_back({6'h2C, 8'h13});
        eq.push_back({AI ? 6'h2D : 6'h2C, 8'h02});
        chk_wr("wburst", eq);
        txb[0] = 8'h00;
        xact(8'h0B, 8'h2C, 1);
        chk("rb 2C", rxb[0], AI ? 8'h13 : 8'h02);
        xact(8'h0B, 8'h2D, 1);
        chk("rb 2D", rxb[0], AI ? 8'h02 : 8'h00);

        cs_on();
        spi_bits(8'h0B, 8, d);
        spi_bits(8'h08, 8, d);
        sample(12'h456, 12'h123, 12'h7FF);
        spi_bits(8'h00, 8, d);
        cs_off();
        chk("shadow old X", d, 8'h9A);
        xact(8'h0B, 8'h08, 1);
        chk("shadow new X", rxb[0], 8'h45);

        got_q.delete();
        cs_on();
        spi_bits(8'h0A, 8, d);
        spi_bits(8'h2C, 8, d);
        spi_bits(8'hFF, 5, d);
        cs_off();
        chk("abort wr", got_q.size(), 0);
        txb[0] = 8'h00;
        xact(8'h0B, 8'h2C, 1);
        chk("abort 2C", rxb[0], AI ? 8'h13 : 8'h02);

        txb[0] = 8'h02;
        xact(8'h0A, 8'h2D, 1);
        chk("cfg 2D wr", got_q.size(), 1);
        sample(12'h456, 12'h123, 12'h7FF);
        txb[0] = 8'h52;
        xact(8'h0A, 8'h1F, 1);
        eq.delete();
        eq.push_back({6'h1F, 8'h52});
        chk_wr("softrst", eq);
        txb[0] = 8'h00;
        xact(8'h0B, 8'h2D, 1);
        chk("softrst 2D", rxb[0], 8'h00);
        xact(8'h0B, 8'h2C, 1);
        chk("softrst 2C", rxb[0], 8'h00);
        xact(8'h0B, 8'h0B, 1);
        chk("softrst status", rxb[0], 8'h00);

        e = '{8'hAD, 8'h1D, 8'hF2, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) txb[i] = 8'h00;
        xact(8'h0B, 8'h00, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("3b read b%0d", i), rxb[i], AI ? e[i] : e[0]);
        chk("miso after csn", miso, 1'b0);

        xact(8'h0B, 8'h3F, 2);
        chk("wrap b0", rxb[0], 8'h00);
        chk("wrap b1", rxb[1], AI ? 8'hAD : 8'h00);

        txb[0] = 8'h52;
        xact(8'h0A, 8'h1F, 1);
        foreach (m_ram[k]) m_ram[k] = '0;
        sample(12'($urandom), 12'($urandom), 12'($urandom));
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0)
                sample(12'($urandom), 12'($urandom), 12'($urandom));
            rnd_xact(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
